// File: rtl/mips_lite_sim_core.sv
// MIPS-Lite ISA simulator: one instruction per clock from a unified memory,
// with instruction-mix and 5-stage pipeline stall statistics.
module mips_lite_sim_core #(
   parameter int MEM_BYTES = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_we,
   input  logic [9:0]  load_addr,
   input  logic [31:0] load_data,
   input  logic        start,
   output logic        done,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data,
   output logic [31:0] reg_written,
   input  logic [9:0]  mem_sel,
   output logic [31:0] mem_data,
   output logic        mem_accessed,
   output logic [31:0] program_counter,
   output logic [31:0] total_instr_count,
   output logic [31:0] arith_instr_count,
   output logic [31:0] logic_instr_count,
   output logic [31:0] mem_count,
   output logic [31:0] control_count,
   output logic [31:0] branch_taken,
   output logic [31:0] nf_cycles,
   output logic [31:0] nf_stalls,
   output logic [31:0] nf_hazards,
   output logic [31:0] fw_cycles,
   output logic [31:0] fw_stalls,
   output logic [31:0] fw_hazards
);
   localparam int WORDS = MEM_BYTES / 4;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   state_t state_q, state_d;

   logic [31:0] mem [WORDS];
   logic [31:0] regs [32];
   logic [WORDS-1:0] acc_q;

   logic        p1_v, p2_v, p1_ld;
   logic [4:0]  p1_r, p2_r;
   logic [1:0]  p1_st;

   logic [31:0] instr, a, b, imm, alu_b, ea, res, pc_n;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd, wr_idx;
   logic        is_alu, wr_en, use_rs, use_rt, st_en, is_ld, halt, taken;
   logic        c_ar, c_lg, c_mem, c_ctl;
   logic [1:0]  nf_rs, nf_rt, nf_st;
   logic        fw_st;

   assign instr = mem[pc_q_idx()];
   function automatic logic [9:0] pc_q_idx();
      return program_counter[11:2];
   endfunction

   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign imm    = {{16{instr[15]}}, instr[15:0]};
   assign a      = regs[rs];
   assign b      = regs[rt];
   assign alu_b  = op[0] ? imm : b;
   assign ea     = a + imm;
   assign is_alu = (op <= 6'd11);

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = rt;
      res    = '0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      st_en  = 1'b0;
      is_ld  = 1'b0;
      halt   = 1'b0;
      taken  = 1'b0;
      c_ar   = 1'b0;
      c_lg   = 1'b0;
      c_mem  = 1'b0;
      c_ctl  = 1'b0;
      pc_n   = program_counter + 32'd4;
      unique case (1'b1)
         is_alu: begin
            wr_en  = 1'b1;
            wr_idx = op[0] ? rt : rd;
            use_rs = 1'b1;
            use_rt = !op[0];
            c_ar   = (op <= 6'd5);
            c_lg   = (op >= 6'd6);
            case (op[3:1])
               3'd0:    res = a + alu_b;
               3'd1:    res = a - alu_b;
               3'd2:    res = a * alu_b;
               3'd3:    res = a | alu_b;
               3'd4:    res = a & alu_b;
               default: res = a ^ alu_b;
            endcase
         end
         op == 6'd12: begin
            res    = mem[ea[11:2]];
            wr_en  = 1'b1;
            use_rs = 1'b1;
            is_ld  = 1'b1;
            c_mem  = 1'b1;
         end
         op == 6'd13: begin
            st_en  = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
            c_mem  = 1'b1;
         end
         op == 6'd14: begin
            use_rs = 1'b1;
            c_ctl  = 1'b1;
            taken  = (a == 32'd0);
         end
         op == 6'd15: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            c_ctl  = 1'b1;
            taken  = (a == b);
         end
         op == 6'd16: begin
            use_rs = 1'b1;
            c_ctl  = 1'b1;
            taken  = 1'b1;
         end
         op == 6'd17: begin
            halt   = 1'b1;
            c_ctl  = 1'b1;
            pc_n   = program_counter;
         end
         default: ;
      endcase
      if (op == 6'd16)
         pc_n = a;
      else if (taken)
         pc_n = program_counter + {imm[29:0], 2'b00};
   end

   // Hazard distance is measured on the dynamic stream, not static code.
   assign nf_rs = !use_rs ? 2'd0 :
                  (p1_v && rs == p1_r) ? 2'd2 :
                  (p2_v && rs == p2_r && p1_st == 2'd0) ? 2'd1 : 2'd0;
   assign nf_rt = !use_rt ? 2'd0 :
                  (p1_v && rt == p1_r) ? 2'd2 :
                  (p2_v && rt == p2_r && p1_st == 2'd0) ? 2'd1 : 2'd0;
   assign nf_st = (nf_rs > nf_rt) ? nf_rs : nf_rt;
   assign fw_st = p1_v && p1_ld &&
                  ((use_rs && rs == p1_r) || (use_rt && rt == p1_r));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (halt) state_d = HALTED;
         default: ;
      endcase
   end

   assign done         = (state_q == HALTED);
   assign reg_data     = regs[reg_sel];
   assign mem_data     = mem[mem_sel];
   assign mem_accessed = acc_q[mem_sel];

   // Memory survives reset so a program can be rerun without reloading.
   always_ff @(posedge clock) begin
      if (state_q == IDLE && load_we)
         mem[load_addr] <= load_data;
      else if (state_q == RUN && st_en)
         mem[ea[11:2]] <= b;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q           <= IDLE;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         reg_written       <= '0;
         acc_q             <= '0;
         program_counter   <= '0;
         total_instr_count <= '0;
         arith_instr_count <= '0;
         logic_instr_count <= '0;
         mem_count         <= '0;
         control_count     <= '0;
         branch_taken      <= '0;
         nf_cycles         <= '0;
         nf_stalls         <= '0;
         nf_hazards        <= '0;
         fw_cycles         <= '0;
         fw_stalls         <= '0;
         fw_hazards        <= '0;
         p1_v              <= 1'b0;
         p2_v              <= 1'b0;
         p1_ld             <= 1'b0;
         p1_r              <= '0;
         p2_r              <= '0;
         p1_st             <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            program_counter <= '0;
            nf_cycles       <= 32'd4;
            fw_cycles       <= 32'd4;
         end
         if (state_q == RUN) begin
            if (wr_en) begin
               regs[wr_idx]        <= res;
               reg_written[wr_idx] <= 1'b1;
            end
            if (c_mem) acc_q[ea[11:2]] <= 1'b1;
            program_counter   <= pc_n;
            total_instr_count <= total_instr_count + 32'd1;
            arith_instr_count <= arith_instr_count + {31'd0, c_ar};
            logic_instr_count <= logic_instr_count + {31'd0, c_lg};
            mem_count         <= mem_count + {31'd0, c_mem};
            control_count     <= control_count + {31'd0, c_ctl};
            branch_taken      <= branch_taken + {31'd0, taken};
            nf_stalls  <= nf_stalls + {30'd0, nf_st};
            nf_hazards <= nf_hazards + {31'd0, nf_st != 2'd0};
            nf_cycles  <= nf_cycles + 32'd1 + {30'd0, nf_st}
                          + {30'd0, taken, 1'b0};
            fw_stalls  <= fw_stalls + {31'd0, fw_st};
            fw_hazards <= fw_hazards + {31'd0, fw_st};
            fw_cycles  <= fw_cycles + 32'd1 + {31'd0, fw_st}
                          + {30'd0, taken, 1'b0};
            if (taken) begin
               p1_v  <= 1'b0;
               p2_v  <= 1'b0;
               p1_ld <= 1'b0;
               p1_st <= '0;
            end else begin
               p2_v  <= p1_v;
               p2_r  <= p1_r;
               p1_v  <= wr_en;
               p1_r  <= wr_idx;
               p1_ld <= is_ld;
               p1_st <= nf_st;
            end
         end
      end
   end
endmodule

// File: tb/tb_mips_lite_sim_core.sv
// Directed self-checking bench for mips_lite_sim_core.
module tb_mips_lite_sim_core;
   logic        clock = 0;
   logic        reset = 0;
   logic        load_we = 0;
   logic [9:0]  load_addr = 0;
   logic [31:0] load_data = 0;
   logic        start = 0;
   logic        done;
   logic [4:0]  reg_sel = 0;
   logic [31:0] reg_data, reg_written;
   logic [9:0]  mem_sel = 0;
   logic [31:0] mem_data;
   logic        mem_accessed;
   logic [31:0] program_counter, total_instr_count, arith_instr_count;
   logic [31:0] logic_instr_count, mem_count, control_count, branch_taken;
   logic [31:0] nf_cycles, nf_stalls, nf_hazards;
   logic [31:0] fw_cycles, fw_stalls, fw_hazards;
   int checks = 0;
   int failures = 0;

   mips_lite_sim_core dut (
      .clock(clock), .reset(reset), .load_we(load_we),
      .load_addr(load_addr), .load_data(load_data), .start(start),
      .done(done), .reg_sel(reg_sel), .reg_data(reg_data),
      .reg_written(reg_written), .mem_sel(mem_sel), .mem_data(mem_data),
      .mem_accessed(mem_accessed), .program_counter(program_counter),
      .total_instr_count(total_instr_count),
      .arith_instr_count(arith_instr_count),
      .logic_instr_count(logic_instr_count), .mem_count(mem_count),
      .control_count(control_count), .branch_taken(branch_taken),
      .nf_cycles(nf_cycles), .nf_stalls(nf_stalls),
      .nf_hazards(nf_hazards), .fw_cycles(fw_cycles),
      .fw_stalls(fw_stalls), .fw_hazards(fw_hazards)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] enc_r(int op, int rs, int rt, int rd);
      return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   task automatic reset_dut();
      reset = 1;
      @(negedge clock);
      reset = 0;
      @(negedge clock);
   endtask

   task automatic load_word(input int addr, input logic [31:0] data);
      load_we = 1;
      load_addr = addr[9:0];
      load_data = data;
      @(negedge clock);
      load_we = 0;
   endtask

   task automatic run_prog();
      start = 1;
      @(negedge clock);
      start = 0;
      for (int i = 0; i < 200 && !done; i++) @(negedge clock);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL run_timeout got=%b exp=1", done);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (program_counter !== 32'd0) begin failures++; $display("FAIL rst_pc got=%h exp=0", program_counter); end
      checks++; if (total_instr_count !== 32'd0) begin failures++; $display("FAIL rst_total got=%0d exp=0", total_instr_count); end
      checks++; if (reg_written !== 32'd0) begin failures++; $display("FAIL rst_written got=%h exp=0", reg_written); end
      @(negedge clock);
      reset = 0;
      @(negedge clock);
   endtask

   task automatic load_add_prog();
      load_word(0, enc_i(1, 0, 1, 5));
      load_word(1, enc_i(1, 0, 2, 7));
      load_word(2, enc_r(0, 1, 2, 3));
      load_word(3, enc_i(17, 0, 0, 0));
   endtask

   task automatic check_add_results(input string tag);
      reg_sel = 3; #1;
      checks++; if (reg_data !== 32'd12) begin failures++; $display("FAIL %s_r3 got=%0d exp=12", tag, reg_data); end
      checks++; if (reg_written !== 32'h0000000E) begin failures++; $display("FAIL %s_written got=%h exp=e", tag, reg_written); end
      checks++; if (total_instr_count !== 32'd4) begin failures++; $display("FAIL %s_total got=%0d exp=4", tag, total_instr_count); end
      checks++; if (arith_instr_count !== 32'd3) begin failures++; $display("FAIL %s_arith got=%0d exp=3", tag, arith_instr_count); end
      checks++; if (control_count !== 32'd1) begin failures++; $display("FAIL %s_ctrl got=%0d exp=1", tag, control_count); end
      checks++; if (branch_taken !== 32'd0) begin failures++; $display("FAIL %s_taken got=%0d exp=0", tag, branch_taken); end
      checks++; if (nf_stalls !== 32'd2) begin failures++; $display("FAIL %s_nfst got=%0d exp=2", tag, nf_stalls); end
      checks++; if (nf_hazards !== 32'd1) begin failures++; $display("FAIL %s_nfhz got=%0d exp=1", tag, nf_hazards); end
      checks++; if (nf_cycles !== 32'd10) begin failures++; $display("FAIL %s_nfcyc got=%0d exp=10", tag, nf_cycles); end
      checks++; if (fw_stalls !== 32'd0) begin failures++; $display("FAIL %s_fwst got=%0d exp=0", tag, fw_stalls); end
      checks++; if (fw_cycles !== 32'd8) begin failures++; $display("FAIL %s_fwcyc got=%0d exp=8", tag, fw_cycles); end
      checks++; if (program_counter !== 32'd12) begin failures++; $display("FAIL %s_pc got=%h exp=c", tag, program_counter); end
   endtask

   task automatic test_arith();
      reset_dut();
      load_add_prog();
      run_prog();
      check_add_results("add");
      start = 1; load_we = 1; load_addr = 0; load_data = 32'hDEAD_BEEF;
      @(negedge clock);
      start = 0; load_we = 0;
      mem_sel = 0; #1;
      checks++; if (mem_data !== enc_i(1, 0, 1, 5)) begin failures++; $display("FAIL halted_load got=%h exp=%h", mem_data, enc_i(1, 0, 1, 5)); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL halted_sticky got=%b exp=1", done); end
   endtask

   task automatic test_load_use();
      reset_dut();
      load_word(32'h40, 32'h11);
      load_word(0, enc_i(12, 0, 1, 32'h100));
      load_word(1, enc_r(0, 1, 1, 2));
      load_word(2, enc_i(17, 0, 0, 0));
      run_prog();
      reg_sel = 2; mem_sel = 10'h40; #1;
      checks++; if (reg_data !== 32'h22) begin failures++; $display("FAIL ld_r2 got=%h exp=22", reg_data); end
      checks++; if (mem_count !== 32'd1) begin failures++; $display("FAIL ld_memcnt got=%0d exp=1", mem_count); end
      checks++; if (mem_accessed !== 1'b1) begin failures++; $display("FAIL ld_acc got=%b exp=1", mem_accessed); end
      mem_sel = 10'h41; #1;
      checks++; if (mem_accessed !== 1'b0) begin failures++; $display("FAIL ld_acc_other got=%b exp=0", mem_accessed); end
      checks++; if (nf_stalls !== 32'd2) begin failures++; $display("FAIL ld_nfst got=%0d exp=2", nf_stalls); end
      checks++; if (nf_cycles !== 32'd9) begin failures++; $display("FAIL ld_nfcyc got=%0d exp=9", nf_cycles); end
      checks++; if (fw_stalls !== 32'd1) begin failures++; $display("FAIL ld_fwst got=%0d exp=1", fw_stalls); end
      checks++; if (fw_hazards !== 32'd1) begin failures++; $display("FAIL ld_fwhz got=%0d exp=1", fw_hazards); end
      checks++; if (fw_cycles !== 32'd8) begin failures++; $display("FAIL ld_fwcyc got=%0d exp=8", fw_cycles); end
   endtask

   task automatic test_bz_taken();
      reset_dut();
      load_word(0, enc_i(1, 0, 1, 0));
      load_word(1, enc_i(14, 1, 0, 2));
      load_word(2, enc_i(1, 0, 2, 1));
      load_word(3, enc_i(17, 0, 0, 0));
      run_prog();
      checks++; if (reg_written[2] !== 1'b0) begin failures++; $display("FAIL bz_r2w got=%b exp=0", reg_written[2]); end
      checks++; if (total_instr_count !== 32'd3) begin failures++; $display("FAIL bz_total got=%0d exp=3", total_instr_count); end
      checks++; if (branch_taken !== 32'd1) begin failures++; $display("FAIL bz_taken got=%0d exp=1", branch_taken); end
      checks++; if (program_counter !== 32'd12) begin failures++; $display("FAIL bz_pc got=%h exp=c", program_counter); end
      checks++; if (nf_cycles !== 32'd11) begin failures++; $display("FAIL bz_nfcyc got=%0d exp=11", nf_cycles); end
      checks++; if (fw_cycles !== 32'd9) begin failures++; $display("FAIL bz_fwcyc got=%0d exp=9", fw_cycles); end
   endtask

   task automatic test_sign_ext();
      reset_dut();
      load_word(0, enc_i(1, 0, 1, 32'hFFFF));
      load_word(1, enc_i(5, 1, 2, 32'hFFFF));
      load_word(2, enc_i(11, 1, 3, 32'h00FF));
      load_word(3, enc_i(17, 0, 0, 0));
      run_prog();
      reg_sel = 1; #1;
      checks++; if (reg_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL se_r1 got=%h exp=ffffffff", reg_data); end
      reg_sel = 2; #1;
      checks++; if (reg_data !== 32'd1) begin failures++; $display("FAIL se_r2 got=%h exp=1", reg_data); end
      reg_sel = 3; #1;
      checks++; if (reg_data !== 32'hFFFFFF00) begin failures++; $display("FAIL se_r3 got=%h exp=ffffff00", reg_data); end
      checks++; if (logic_instr_count !== 32'd1) begin failures++; $display("FAIL se_logic got=%0d exp=1", logic_instr_count); end
      checks++; if (arith_instr_count !== 32'd2) begin failures++; $display("FAIL se_arith got=%0d exp=2", arith_instr_count); end
   endtask

   task automatic test_jr();
      reset_dut();
      load_word(0, enc_i(1, 0, 1, 32'h200));
      load_word(1, enc_i(16, 1, 0, 0));
      load_word(2, enc_i(1, 0, 5, 9));
      load_word(32'h80, enc_i(17, 0, 0, 0));
      run_prog();
      checks++; if (branch_taken !== 32'd1) begin failures++; $display("FAIL jr_taken got=%0d exp=1", branch_taken); end
      checks++; if (control_count !== 32'd2) begin failures++; $display("FAIL jr_ctrl got=%0d exp=2", control_count); end
      checks++; if (program_counter !== 32'h200) begin failures++; $display("FAIL jr_pc got=%h exp=200", program_counter); end
      checks++; if (reg_written[5] !== 1'b0) begin failures++; $display("FAIL jr_r5w got=%b exp=0", reg_written[5]); end
   endtask

   task automatic test_back_to_back();
      reset_dut();
      load_word(0, enc_i(1, 0, 1, 32'h55));
      load_word(1, enc_i(13, 0, 1, 32'h80));
      load_word(2, enc_i(12, 0, 2, 32'h80));
      load_word(3, enc_i(15, 1, 2, 2));
      load_word(4, enc_i(1, 0, 3, 1));
      load_word(5, enc_i(17, 0, 0, 0));
      run_prog();
      reg_sel = 2; mem_sel = 10'h20; #1;
      checks++; if (reg_data !== 32'h55) begin failures++; $display("FAIL bb_r2 got=%h exp=55", reg_data); end
      checks++; if (mem_data !== 32'h55) begin failures++; $display("FAIL bb_mem got=%h exp=55", mem_data); end
      checks++; if (mem_accessed !== 1'b1) begin failures++; $display("FAIL bb_acc got=%b exp=1", mem_accessed); end
      checks++; if (reg_written[3] !== 1'b0) begin failures++; $display("FAIL bb_r3w got=%b exp=0", reg_written[3]); end
      checks++; if (program_counter !== 32'd20) begin failures++; $display("FAIL bb_pc got=%0d exp=20", program_counter); end
      checks++; if (mem_count !== 32'd2) begin failures++; $display("FAIL bb_memcnt got=%0d exp=2", mem_count); end
      checks++; if (nf_stalls !== 32'd4) begin failures++; $display("FAIL bb_nfst got=%0d exp=4", nf_stalls); end
      checks++; if (nf_hazards !== 32'd2) begin failures++; $display("FAIL bb_nfhz got=%0d exp=2", nf_hazards); end
      checks++; if (nf_cycles !== 32'd15) begin failures++; $display("FAIL bb_nfcyc got=%0d exp=15", nf_cycles); end
      checks++; if (fw_stalls !== 32'd1) begin failures++; $display("FAIL bb_fwst got=%0d exp=1", fw_stalls); end
      checks++; if (fw_cycles !== 32'd12) begin failures++; $display("FAIL bb_fwcyc got=%0d exp=12", fw_cycles); end
   endtask

   task automatic test_mid_reset();
      reset_dut();
      load_add_prog();
      start = 1;
      @(negedge clock);
      start = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1;
      #1;
      reg_sel = 1; #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mr_done got=%b exp=0", done); end
      checks++; if (total_instr_count !== 32'd0) begin failures++; $display("FAIL mr_total got=%0d exp=0", total_instr_count); end
      checks++; if (nf_cycles !== 32'd0) begin failures++; $display("FAIL mr_nfcyc got=%0d exp=0", nf_cycles); end
      checks++; if (reg_data !== 32'd0) begin failures++; $display("FAIL mr_r1 got=%h exp=0", reg_data); end
      checks++; if (reg_written !== 32'd0) begin failures++; $display("FAIL mr_written got=%h exp=0", reg_written); end
      @(negedge clock);
      reset = 0;
      @(negedge clock);
      run_prog();
      check_add_results("rerun");
   endtask

   initial begin
      test_reset();
      test_arith();
      test_load_use();
      test_bz_taken();
      test_sign_ext();
      test_jr();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mips_lite_sim_core.md
# mips_lite_sim_core

Cycle-driven MIPS-Lite instruction-set simulator that executes a program from an internal 4 KB unified memory. It produces the architectural result (registers, memory, PC), instruction-mix statistics, and timing statistics for a 5-stage pipeline in two modes: without forwarding and with forwarding. It is the single execution/statistics engine behind the top-level report; the report reads its outputs after `done`.

## Interface
- `MEM_BYTES`, 4096: unified byte-addressed memory size; big-endian words.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_we` in 1: writes `load_data` to word `load_addr`; honoured only in IDLE.
- `load_addr` in 10: word index.
- `load_data` in 32: memory image word.
- `start` in 1: IDLE→RUN, PC=0.
- `done` out 1: high in HALTED.
- `reg_sel` in 5 / `reg_data` out 32: combinational register read.
- `reg_written` out 32: bit i set once Ri has been written.
- `mem_sel` in 10 / `mem_data` out 32, `mem_accessed` out 1: combinational word read; flag set if that word was touched by LDW/STW.
- `program_counter`, `total_instr_count`, `arith_instr_count`, `logic_instr_count`, `mem_count`, `control_count`, `branch_taken` out 32 each.
- `nf_cycles`, `nf_stalls`, `nf_hazards`, `fw_cycles`, `fw_stalls`, `fw_hazards` out 32 each.

## Operation
- Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11] (R-type), imm[15:0] sign-extended for every I-type.
- Opcodes (decimal):
  - Arithmetic: ADD 0, ADDI 1, SUB 2, SUBI 3, MUL 4, MULI 5.
  - Logical: OR 6, ORI 7, AND 8, ANDI 9, XOR 10, XORI 11.
  - Memory: LDW 12, STW 13.
  - Control: BZ 14, BEQ 15, JR 16, HALT 17.
  - Any other opcode: NOP, counted in total only.
- R-type writes rd; I-type ALU and LDW write rt. R0 is an ordinary writable register.
- Arithmetic is 32-bit two's-complement wrap; MUL keeps the low 32 bits.
- LDW/STW address = Rs+imm. Bits [1:0] are ignored; bits [11:2] select the word (wraps mod 4 KB). STW stores Rt.
- Branches:
  - BZ taken if Rs==0; BEQ taken if Rs==Rt. Taken target = PC+4×imm, where PC is the branch's own address.
  - JR: PC=Rs, always counted as taken.
  - Not taken: PC+4.
- Counters: total counts every executed instruction including HALT. `arith`, `logic`, `mem` are by class. `control_count` counts BZ, BEQ, JR and HALT.
- Pipeline model (IF ID EX MEM WB, one issue/cycle), evaluated on the dynamic instruction stream:
  - Sources:
    - R-type: rs, rt.
    - I-type ALU and LDW: rs.
    - STW: rs, rt.
    - BZ, JR: rs.
    - BEQ: rs, rt.
  - No forwarding: a source produced by the previous instruction costs 2 stalls. Otherwise, a source produced two instructions back costs 1 stall, only if the previous instruction stalled 0.
  - Forwarding: only a source produced by an immediately preceding LDW costs 1 stall.
  - Each instruction's stall is the maximum over its sources.
  - A taken branch/JR clears producer history and adds a 2-cycle flush in both modes.
  - `*_stalls` = sum of data stalls; `*_hazards` = number of instructions with nonzero stall.
  - `*_cycles` = total + 4 + stalls + 2×branch_taken.

## Timing
- States: IDLE, RUN, HALTED.
  - IDLE: loads accepted; `start` moves to RUN.
  - RUN: exactly one instruction executes per rising edge; all state and counters update on that edge.
  - HALT executes, is counted, leaves PC at the HALT address, and enters HALTED.
  - HALTED: `done`=1; it persists and ignores `start` and `load_we` until reset.
- Reset (any time, including mid-RUN):
  - IDLE; `done`=0; PC=0; all registers, counters, `reg_written` and accessed flags cleared.
  - Memory contents are preserved.
- `start` asserted with `load_we` in IDLE: the load completes; RUN begins next edge.
- Outputs are registered except the `reg_data`/`mem_data`/`mem_accessed` reads.

## Test plan
- ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; HALT → R3=12, total 4, arith 3, control 1, taken 0; nf_stalls 2, nf_hazards 1, nf_cycles 10; fw_stalls 0, fw_cycles 8.
- mem[0x100]=0x11; LDW R1,0x100(R0); ADD R2,R1,R1; HALT → R2=0x22, mem_count 1, word 0x40 accessed; nf_stalls 2, nf_cycles 9; fw_stalls 1, fw_hazards 1, fw_cycles 8.
- ADDI R1,R0,0; BZ R1,2; ADDI R2,R0,1; HALT(at 12) → R2 not written, total 3, taken 1, PC 12; nf_cycles 11, fw_cycles 9.
- ADDI R1,R0,-1; MULI R2,R1,-1; XORI R3,R1,0x00FF; HALT → R1=0xFFFFFFFF, R2=1, R3=0xFFFFFF00, logic 1.
- ADDI R1,R0,0x200; JR R1; program with HALT at 0x200 → taken 1, control 2, PC 0x200.
- Reset asserted during the third RUN cycle → done 0, counters 0, registers 0; `start` reruns the unchanged image to identical results.
